alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-side controller for the 16-bit ALU datapath: accepts opcode+operand commands over a
//  valid/ready handshake and encodes the opcode into the 12-bit one-hot select consumed by the
//  ALU result mux. Drives operands and select, waits for the combinational result to settle,
//  captures it into an accumulator and returns it over a valid/ready response channel.
//  One command in flight at a time; this block sits between the host/testbench and the ALU.
// PARAMETERS
//  WIDTH   16  datapath width (operands, result, accumulator)
//  SEL_W   12  one-hot select width; bit n = opcode n
//  SETTLE   1  extra cycles the select is held before capture (0..15)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept a command
//  cmd_op     in   4      opcode (map below)
//  cmd_a      in   WIDTH  operand A (ignored when cmd_use_acc=1)
//  cmd_b      in   WIDTH  operand B / shift amount
//  cmd_use_acc in  1      1: operand A = acc
//  alu_a      out  WIDTH  operand A to ALU
//  alu_b      out  WIDTH  operand B to ALU
//  alu_sel    out  SEL_W  one-hot op select to ALU result mux
//  alu_sub    out  1      add/sub unit mode, 1 = subtract
//  alu_res    in   WIDTH  ALU mux result
//  alu_carry  in   1      add/sub carry/borrow out
//  rsp_valid  out  1      response present
//  rsp_ready  in   1      consumer accepts response
//  rsp_data   out  WIDTH  captured result
//  rsp_carry  out  1      captured carry (ADD/SUB only, else 0)
//  rsp_err    out  1      illegal opcode
//  acc        out  WIDTH  accumulator (last successful result)
// BEHAVIOUR
//  Opcodes: 0 AND,1 OR,2 NOT,3 XOR,4 NAND,5 NOR,6 XNOR,7 ADD,8 SUB,9 SHR,10 SHL,11 CLEAR;
//   12-15 illegal. alu_sel = 1<<op for legal ops (e.g. ADD=12'h080, CLEAR=12'h800).
//  Reset: state IDLE; alu_sel, alu_a, alu_b, alu_sub, rsp_* , acc all 0; cmd_ready 0 during rst.
//  States: IDLE -> EXEC -> RESP -> IDLE; IDLE -> RESP directly on illegal opcode.
//  IDLE: cmd_ready=1, alu_sel=0. On cmd_valid&cmd_ready latch op, operands (A muxed by
//   cmd_use_acc using acc value at accept edge), go EXEC (legal) or RESP with rsp_err=1,
//   rsp_data=0, rsp_carry=0, acc unchanged (illegal).
//  EXEC: cmd_ready=0; alu_sel/alu_a/alu_b/alu_sub registered and stable for SETTLE+1 cycles;
//   alu_sub=1 only for SUB. On the last EXEC edge: rsp_data<=alu_res, acc<=alu_res,
//   rsp_carry<=alu_carry if ADD/SUB else 0, rsp_err<=0. CLEAR forces rsp_data=0, acc=0
//   regardless of alu_res. Go RESP; alu_sel returns to 0.
//  Latency: accept at edge E -> alu_sel valid cycles E+1..E+1+SETTLE -> rsp_valid from E+2+SETTLE.
//   Illegal: rsp_valid from E+1.
//  RESP: rsp_valid=1; rsp_data/carry/err held stable until rsp_valid&rsp_ready; then IDLE,
//   rsp_valid=0 next cycle; cmd_ready returns that same cycle (no same-cycle bypass).
//  cmd inputs ignored outside IDLE; rsp_ready ignored outside RESP.
//  Arithmetic: all WIDTH-bit, wrap-around; sequencer does no computation beyond CLEAR forcing.
//  rst mid-EXEC or mid-RESP: in-flight op dropped, no response emitted, acc cleared.
//  SETTLE counter is 4 bits; SETTLE=0 gives one EXEC cycle.
// TESTING
//  ADD a=16'h1234 b=16'h0001 -> alu_sel=12'h080, alu_sub=0 for 2 cycles; rsp_data=16'h1235, acc=16'h1235.
//  SUB a=16'h0000 b=16'h0001 -> alu_sub=1, sel=12'h100; rsp_data=16'hFFFF, rsp_carry per ALU model.
//  Chain: AND a=16'hFF0F b=16'h0FFF, then OR use_acc=1 b=16'hF000 -> alu_a=16'h0F0F, rsp_data=16'hFF0F.
//  Illegal op 4'hD -> rsp_valid one cycle after accept, rsp_err=1, alu_sel never nonzero, acc unchanged.
//  Backpressure: rsp_ready low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, new cmd ignored.
//  CLEAR after acc=16'hBEEF -> sel=12'h800, acc=0; rst asserted mid-EXEC -> no rsp_valid, all outputs 0.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// ============================================================================
//  Module      : alu_cmd_sequencer_if
//  Description : Command, ALU-drive and response bundle of the ALU sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_err;
    logic [WIDTH-1:0] acc;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  alu_res, alu_carry, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, alu_sub,
        output rsp_valid, rsp_data, rsp_carry, rsp_err, acc
    );

    // Host / ALU side
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output alu_res, alu_carry, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, alu_sub,
        input  rsp_valid, rsp_data, rsp_carry, rsp_err, acc
    );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Accepts ALU commands, drives one-hot select and operands,
//                captures the settled result into the accumulator and responds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SEL_W  = 12,
    parameter int SETTLE = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_cmd_sequencer_if.slave bus
);

    localparam logic [3:0]       c_op_add   = 4'd7;
    localparam logic [3:0]       c_op_sub   = 4'd8;
    localparam logic [3:0]       c_op_clear = 4'd11;
    localparam logic [3:0]       c_num_ops  = 4'd12;
    localparam logic [3:0]       c_settle   = 4'(SETTLE);
    localparam logic [SEL_W-1:0] c_sel_one  = SEL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_cmd_ready;
    logic             w_rsp_valid;
    logic             w_accept;
    logic             w_legal;
    logic             w_last;

    logic [3:0]       r_op;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [SEL_W-1:0] r_sel;
    logic             r_sub;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_carry;
    logic             r_rsp_err;
    logic [WIDTH-1:0] r_acc;

    assign w_legal  = (bus.cmd_op < c_num_ops);
    assign w_accept = bus.cmd_valid && w_cmd_ready;
    assign w_last   = (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Held low while rst is high so nothing is accepted during reset
                w_cmd_ready = !rst;
                if (w_accept) begin
                    w_state_nxt = w_legal ? S_EXEC : S_RESP;
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_sub       <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_acc       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_op  <= bus.cmd_op;
                            r_sel <= c_sel_one << bus.cmd_op;
                            r_a   <= bus.cmd_use_acc ? r_acc : bus.cmd_a;
                            r_b   <= bus.cmd_b;
                            r_sub <= (bus.cmd_op == c_op_sub);
                            r_cnt <= c_settle;
                        end else begin
                            r_rsp_data  <= '0;
                            r_rsp_carry <= 1'b0;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_last) begin
                        // CLEAR ignores whatever the mux presents
                        r_rsp_data  <= (r_op == c_op_clear) ? '0 : bus.alu_res;
                        r_acc       <= (r_op == c_op_clear) ? '0 : bus.alu_res;
                        r_rsp_carry <= ((r_op == c_op_add) || (r_op == c_op_sub)) ?
                                       bus.alu_carry : 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_sel       <= '0;
                        r_sub       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.alu_sel   = r_sel;
    assign bus.alu_sub   = r_sub;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_carry = r_rsp_carry;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.acc       = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Self-checking bench for alu_cmd_sequencer with a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

    localparam int WIDTH  = 16;
    localparam int SEL_W  = 12;
    localparam int SETTLE = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    alu_cmd_sequencer_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    alu_cmd_sequencer #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W),
        .SETTLE(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ALU stand-in: garbage when no select (or CLEAR) so mis-timed captures show
    logic [16:0] w_t;
    always_comb begin
        w_t           = '0;
        bus.alu_res   = 16'hDEAD;
        bus.alu_carry = 1'b0;
        case (bus.alu_sel)
            12'h001: bus.alu_res = bus.alu_a & bus.alu_b;
            12'h002: bus.alu_res = bus.alu_a | bus.alu_b;
            12'h004: bus.alu_res = ~bus.alu_a;
            12'h008: bus.alu_res = bus.alu_a ^ bus.alu_b;
            12'h010: bus.alu_res = ~(bus.alu_a & bus.alu_b);
            12'h020: bus.alu_res = ~(bus.alu_a | bus.alu_b);
            12'h040: bus.alu_res = ~(bus.alu_a ^ bus.alu_b);
            12'h080, 12'h100: begin
                w_t = bus.alu_sub ? ({1'b0, bus.alu_a} - {1'b0, bus.alu_b})
                                  : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
                bus.alu_res   = w_t[15:0];
                bus.alu_carry = w_t[16];
            end
            12'h200: bus.alu_res = bus.alu_a >> bus.alu_b;
            12'h400: bus.alu_res = bus.alu_a << bus.alu_b;
            default: bus.alu_res = 16'hDEAD;
        endcase
    end

    // Reference: {err, carry, data}
    function automatic logic [17:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] d;
        logic        c;
        logic        e;
        d = '0; c = 1'b0; e = 1'b0;
        case (op)
            4'd0:  d = a & b;
            4'd1:  d = a | b;
            4'd2:  d = ~a;
            4'd3:  d = a ^ b;
            4'd4:  d = ~(a & b);
            4'd5:  d = ~(a | b);
            4'd6:  d = ~(a ^ b);
            4'd7:  begin d = a + b; c = (int'(a) + int'(b)) > 65535; end
            4'd8:  begin d = a - b; c = (a < b); end
            4'd9:  d = (b >= 16) ? 16'h0 : 16'(int'(a) / (1 << b));
            4'd10: d = (b >= 16) ? 16'h0 : 16'(int'(a) * (1 << b));
            4'd11: d = 16'h0;
            default: e = 1'b1;
        endcase
        return {e, c, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the sequencer back in IDLE
    task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic ua, input logic [15:0] exp_a, input int stall,
                           output logic [15:0] d, output logic c, output logic e);
        int   t;
        int   lat;
        logic bad;
        logic bad_stall;
        t = 0;
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", 32'(t < 50), 32'd1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_use_acc = ua;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 16'($urandom);
        bus.cmd_b     = 16'($urandom);
        lat = 0;
        bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.rsp_valid) begin
                if (op < 4'd12) begin
                    if (bus.alu_sel !== (12'h001 << op) || bus.alu_sub !== (op == 4'd8) ||
                        bus.alu_a !== exp_a || bus.alu_b !== b) bad = 1'b1;
                end else if (bus.alu_sel !== 12'h000) begin
                    bad = 1'b1;
                end
                if (bus.cmd_ready !== 1'b0) bad = 1'b1;
            end else if (bus.alu_sel !== 12'h000) begin
                bad = 1'b1;
            end
        end while (!bus.rsp_valid && lat < 50);
        chk($sformatf("latency op%0d", op), 32'(lat), (op < 4'd12) ? 32'(2 + SETTLE) : 32'd1);
        chk($sformatf("exec_drive op%0d", op), 32'(bad), 32'd0);
        d = bus.rsp_data;
        c = bus.rsp_carry;
        e = bus.rsp_err;
        bad_stall = 1'b0;
        for (int i = 0; i < stall; i++) begin
            bus.cmd_valid   = 1'b1;
            bus.cmd_op      = 4'($urandom_range(0, 11));
            bus.cmd_a       = 16'($urandom);
            bus.cmd_use_acc = 1'b0;
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d || bus.rsp_carry !== c ||
                bus.rsp_err !== e || bus.cmd_ready !== 1'b0 || bus.alu_sel !== 12'h000)
                bad_stall = 1'b1;
        end
        if (stall > 0) chk("backpressure_hold", 32'(bad_stall), 32'd0);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ua;
        logic [15:0] exp_a;
        int          stall;
        logic [15:0] d;
        logic        c;
        logic        e;
        logic [15:0] acc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [15:0] d;
        logic        c;
        logic        e;
        logic [15:0] model_acc;
        logic [15:0] a_eff;
        logic [17:0] m;
        logic        bad;

        tbl[0]  = '{4'd7,  16'h1234, 16'h0001, 1'b0, 16'h1234, 0, 16'h1235, 1'b0, 1'b0, 16'h1235};
        tbl[1]  = '{4'd8,  16'h0000, 16'h0001, 1'b0, 16'h0000, 0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};
        tbl[2]  = '{4'd0,  16'hFF0F, 16'h0FFF, 1'b0, 16'hFF0F, 0, 16'h0F0F, 1'b0, 1'b0, 16'h0F0F};
        tbl[3]  = '{4'd1,  16'h1111, 16'hF000, 1'b1, 16'h0F0F, 0, 16'hFF0F, 1'b0, 1'b0, 16'hFF0F};
        tbl[4]  = '{4'hD,  16'h1234, 16'h5678, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b1, 16'hFF0F};
        tbl[5]  = '{4'd7,  16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        tbl[6]  = '{4'd3,  16'hBEEF, 16'h0000, 1'b0, 16'hBEEF, 5, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF};
        tbl[7]  = '{4'd11, 16'h1234, 16'h5678, 1'b0, 16'h1234, 0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[8]  = '{4'd10, 16'h0001, 16'h000F, 1'b0, 16'h0001, 0, 16'h8000, 1'b0, 1'b0, 16'h8000};
        tbl[9]  = '{4'd9,  16'h8000, 16'h0004, 1'b0, 16'h8000, 0, 16'h0800, 1'b0, 1'b0, 16'h0800};
        tbl[10] = '{4'd2,  16'h00FF, 16'h1234, 1'b0, 16'h00FF, 0, 16'hFF00, 1'b0, 1'b0, 16'hFF00};
        tbl[11] = '{4'd4,  16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFF, 0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[12] = '{4'd5,  16'h0000, 16'h0000, 1'b0, 16'h0000, 2, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF};
        tbl[13] = '{4'd6,  16'h0F0F, 16'hFF00, 1'b0, 16'h0F0F, 0, 16'h0FF0, 1'b0, 1'b0, 16'h0FF0};
        tbl[14] = '{4'd8,  16'h7777, 16'h0001, 1'b1, 16'h0FF0, 0, 16'h0FEF, 1'b0, 1'b0, 16'h0FEF};
        tbl[15] = '{4'hF,  16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1, 16'h0000, 1'b0, 1'b1, 16'h0FEF};

        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_use_acc = 1'b0; bus.rsp_ready = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("cmd_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {bus.alu_sel, bus.alu_sub, bus.rsp_valid, bus.rsp_carry, bus.rsp_err},
            32'd0);
        chk("reset_acc", 32'(bus.acc), 32'd0);
        chk("reset_alu_ab", {bus.alu_a, bus.alu_b}, 32'd0);
        chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            run_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ua, tbl[i].exp_a, tbl[i].stall, d, c, e);
            chk($sformatf("vec%0d data", i), 32'(d), 32'(tbl[i].d));
            chk($sformatf("vec%0d carry", i), 32'(c), 32'(tbl[i].c));
            chk($sformatf("vec%0d err", i), 32'(e), 32'(tbl[i].e));
            chk($sformatf("vec%0d acc", i), 32'(bus.acc), 32'(tbl[i].acc));
        end

        // Reset while an ADD is still executing
        bus.cmd_valid = 1'b1; bus.cmd_op = 4'd7; bus.cmd_a = 16'h0101; bus.cmd_b = 16'h0202;
        bus.cmd_use_acc = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("midexec_sel", 32'(bus.alu_sel), 32'h080);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midexec_rst_outs", {bus.alu_sel, bus.alu_sub, bus.rsp_valid, bus.rsp_err}, 32'd0);
        chk("midexec_rst_acc", 32'(bus.acc), 32'd0);
        chk("midexec_rst_ab", {bus.alu_a, bus.alu_b}, 32'd0);
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.alu_sel !== 12'h000) bad = 1'b1;
        end
        chk("midexec_no_rsp", 32'(bad), 32'd0);

        // Randomized commands against the reference model
        model_acc = 16'h0000;
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            logic        ua;
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = (op == 4'd9 || op == 4'd10) ? 16'($urandom_range(0, 18)) : 16'($urandom);
            ua = 1'($urandom_range(0, 1));
            a_eff = ua ? model_acc : a;
            m = model(op, a_eff, b);
            run_cmd(op, a, b, ua, a_eff, int'($urandom_range(0, 3)), d, c, e);
            if (!m[17]) model_acc = m[15:0];
            chk($sformatf("rnd%0d op%0d result", n, op), {13'd0, e, c, d}, {14'd0, m});
            chk($sformatf("rnd%0d acc", n), 32'(bus.acc), 32'(model_acc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
